// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: data-side interconnect between the core memory port and
// on-chip RAM, ROM port B and a req/ack peripheral port. Every transaction
// returns one registered response (rdata/err) with a one-cycle mem_valid.
// Optional build macro MEM_ALIGN_CHECK_EN: reject byte-enable patterns other
// than single byte, aligned halfword or full word with an error response.
module mem_bus_decoder #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] ROM_BASE = 32'h0000_0000,
  parameter int              ROM_AW   = 18,
  parameter logic [XLEN-1:0] RAM_BASE = 32'h1000_0000,
  parameter int              RAM_AW   = 17,
  parameter logic [XLEN-1:0] PER_BASE = 32'h2000_0000,
  parameter int              PER_AW   = 16,
  parameter int              TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     mem_addr,
  input  logic [XLEN/8-1:0]   mem_byteen,
  input  logic                mem_we,
  input  logic                mem_req,
  input  logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN-1:0]     mem_rdata,
  output logic                mem_valid,
  output logic                mem_err,
  output logic [RAM_AW-3:0]   ram_addr,
  output logic [XLEN/8-1:0]   ram_byteen,
  output logic                ram_we,
  output logic [XLEN-1:0]     ram_wdata,
  input  logic [XLEN-1:0]     ram_rdata,
  output logic [ROM_AW-3:0]   rom_addr,
  output logic                rom_rden,
  input  logic [XLEN-1:0]     rom_rdata,
  output logic [PER_AW-1:0]   per_addr,
  output logic                per_req,
  output logic                per_we,
  output logic [XLEN/8-1:0]   per_byteen,
  output logic [XLEN-1:0]     per_wdata,
  input  logic [XLEN-1:0]     per_rdata,
  input  logic                per_ack
);

  localparam int BW = XLEN / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, PER_WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              sel_rom_q;
  logic              per_req_q;
  logic [PER_AW-1:0] per_addr_q;
  logic              per_we_q;
  logic [BW-1:0]     per_byteen_q;
  logic [XLEN-1:0]   per_wdata_q;
  logic [CW-1:0]     cnt_q;

  logic rom_hit, ram_hit, per_hit, align_ok;
  logic legal_ram, legal_rom_rd, legal_per, idle_req, timeout_hit;

  // Region decode on the upper address bits
  always_comb begin
    rom_hit = (mem_addr[XLEN-1:ROM_AW] == ROM_BASE[XLEN-1:ROM_AW]);
    ram_hit = (mem_addr[XLEN-1:RAM_AW] == RAM_BASE[XLEN-1:RAM_AW]);
    per_hit = (mem_addr[XLEN-1:PER_AW] == PER_BASE[XLEN-1:PER_AW]);
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Accept only byte, aligned halfword and full-word enable patterns
  always_comb begin
    case (mem_byteen)
      BW'(4'b0001), BW'(4'b0010), BW'(4'b0100), BW'(4'b1000),
      BW'(4'b0011), BW'(4'b1100), BW'(4'b1111): align_ok = 1'b1;
      default:                                   align_ok = 1'b0;
    endcase
  end
`else
  // Byte enables pass through unchecked
  always_comb align_ok = 1'b1;
`endif

  // Legal-access qualification and memory strobes, only while IDLE
  always_comb begin
    idle_req     = (state_q == IDLE) && mem_req;
    legal_ram    = ram_hit && align_ok;
    legal_rom_rd = rom_hit && !mem_we && align_ok;
    legal_per    = per_hit && align_ok;
    timeout_hit  = (cnt_q == CW'(TIMEOUT - 1));
    ram_addr     = mem_addr[RAM_AW-1:2];
    ram_byteen   = mem_byteen;
    ram_wdata    = mem_wdata;
    ram_we       = idle_req && mem_we && legal_ram;
    rom_addr     = mem_addr[ROM_AW-1:2];
    rom_rden     = idle_req && legal_rom_rd;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          if (legal_ram && mem_we)           state_d = RESP;
          else if (legal_ram || legal_rom_rd) state_d = MEM_WAIT;
          else if (legal_per)                 state_d = PER_WAIT;
          else                                state_d = RESP;
        end
      end
      MEM_WAIT: state_d = RESP;
      PER_WAIT: if (per_ack || timeout_hit) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Response, peripheral request and timeout datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q      <= '0;
      err_q        <= 1'b0;
      sel_rom_q    <= 1'b0;
      per_req_q    <= 1'b0;
      per_addr_q   <= '0;
      per_we_q     <= 1'b0;
      per_byteen_q <= '0;
      per_wdata_q  <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            err_q     <= !(legal_ram || legal_rom_rd || legal_per);
            sel_rom_q <= rom_hit;
            if (legal_per && !legal_ram && !legal_rom_rd) begin
              per_req_q    <= 1'b1;
              per_addr_q   <= mem_addr[PER_AW-1:0];
              per_we_q     <= mem_we;
              per_byteen_q <= mem_byteen;
              per_wdata_q  <= mem_wdata;
              cnt_q        <= '0;
            end
          end
        end
        MEM_WAIT: rdata_q <= sel_rom_q ? rom_rdata : ram_rdata;
        PER_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // An ack in the timeout cycle still completes cleanly
          if (per_ack) begin
            per_req_q <= 1'b0;
            err_q     <= 1'b0;
            if (!per_we_q) rdata_q <= per_rdata;
          end else if (timeout_hit) begin
            per_req_q <= 1'b0;
            err_q     <= 1'b1;
          end
        end
        RESP:    err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  // Registered response and peripheral outputs
  always_comb begin
    mem_rdata  = rdata_q;
    mem_valid  = (state_q == RESP);
    mem_err    = err_q;
    per_req    = per_req_q;
    per_addr   = per_addr_q;
    per_we     = per_we_q;
    per_byteen = per_byteen_q;
    per_wdata  = per_wdata_q;
  end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Scoreboard bench for mem_bus_decoder: directed transactions push expected
// responses; a negedge monitor pops and compares whenever mem_valid is high.
module tb_mem_bus_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic        mem_we, mem_req, mem_valid, mem_err;
  logic [14:0] ram_addr;
  logic [3:0]  ram_byteen;
  logic        ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic [15:0] rom_addr;
  logic        rom_rden;
  logic [31:0] rom_rdata;
  logic [15:0] per_addr;
  logic        per_req, per_we, per_ack;
  logic [3:0]  per_byteen;
  logic [31:0] per_wdata, per_rdata;

  mem_bus_decoder #(.XLEN(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_byteen(mem_byteen), .mem_we(mem_we),
    .mem_req(mem_req), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_err(mem_err),
    .ram_addr(ram_addr), .ram_byteen(ram_byteen), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_rdata(rom_rdata),
    .per_addr(per_addr), .per_req(per_req), .per_we(per_we),
    .per_byteen(per_byteen), .per_wdata(per_wdata), .per_rdata(per_rdata),
    .per_ack(per_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: byte-enabled write, read data one cycle after the address
  logic [31:0] ram_m [0:1023];
  initial for (int i = 0; i < 1024; i++) ram_m[i] = '0;
  always @(posedge clk) begin
    ram_rdata <= ram_m[ram_addr[9:0]];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) ram_m[ram_addr[9:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  // ROM model: word 2 holds 0x12345678, others 0xB000_0000 | word address
  function automatic logic [31:0] rom_word(input logic [15:0] a);
    return (a == 16'd2) ? 32'h1234_5678 : (32'hB000_0000 | {16'h0, a});
  endfunction
  always @(posedge clk) if (rom_rden) rom_rdata <= rom_word(rom_addr);

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          issue;
    int          lat;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] exp_rdata;
  int          t_issue;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every response is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && mem_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got response with no expectation at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_err"}, {31'b0, mem_err}, {31'b0, e.err});
        check({e.name, "_rdata"}, mem_rdata, e.rdata);
        check({e.name, "_lat"}, cyc - e.issue, e.lat);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    mem_addr   = a;
    mem_we     = we;
    mem_byteen = be;
    mem_wdata  = wd;
    mem_req    = 1'b1;
    t_issue    = cyc;
    #1;
  endtask

  task automatic expect_resp(input string n, input logic err, input logic [31:0] rd,
                             input int lat);
    sbq.push_back('{n, err, rd, t_issue, lat});
    exp_rdata = rd;
  endtask

  // Hold the request until mem_valid; optionally act as the peripheral
  task automatic finish_txn(input string n, input int ack_after, input logic [31:0] ack_data,
                            input int limit, input bit chk_per, input logic [15:0] exp_paddr);
    bit seen = 0;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      per_ack = 1'b0;
      if (mem_valid) begin
        seen = 1;
        if (chk_per) check({n, "_per_req_drop"}, {31'b0, per_req}, 32'd0);
        break;
      end
      if (k == 1 && chk_per) begin
        check({n, "_per_req"}, {31'b0, per_req}, 32'd1);
        check({n, "_per_addr"}, {16'b0, per_addr}, {16'b0, exp_paddr});
        check({n, "_per_we"}, {31'b0, per_we}, {31'b0, mem_we});
        check({n, "_per_be"}, {28'b0, per_byteen}, {28'b0, mem_byteen});
        check({n, "_per_wdata"}, per_wdata, mem_wdata);
      end
      if (k == ack_after) begin
        per_ack   = 1'b1;
        per_rdata = ack_data;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no mem_valid within %0d cycles", n, limit);
    end
    mem_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_byteen = '0; mem_wdata = '0;
    mem_req = 1'b0; per_ack = 1'b0; per_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_err", {31'b0, mem_err}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_per_req", {31'b0, per_req}, 32'd0);
    rst = 1'b0;
    exp_rdata = '0;
    @(posedge clk);
    #1;

    // RAM write then read back
    issue(32'h1000_0010, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    check("ram_wr_we", {31'b0, ram_we}, 32'd1);
    check("ram_wr_addr", {17'b0, ram_addr}, 32'd4);
    check("ram_wr_rom_rden", {31'b0, rom_rden}, 32'd0);
    expect_resp("ram_wr", 1'b0, exp_rdata, 1);
    finish_txn("ram_wr", 0, '0, 10, 0, '0);

    issue(32'h1000_0010, 1'b0, 4'b1111, '0);
    check("ram_rd_we", {31'b0, ram_we}, 32'd0);
    expect_resp("ram_rd", 1'b0, 32'hDEAD_BEEF, 2);
    finish_txn("ram_rd", 0, '0, 10, 0, '0);

    // ROM read, then illegal ROM write
    issue(32'h0000_0008, 1'b0, 4'b1111, '0);
    check("rom_rd_rden", {31'b0, rom_rden}, 32'd1);
    check("rom_rd_addr", {16'b0, rom_addr}, 32'd2);
    expect_resp("rom_rd", 1'b0, 32'h1234_5678, 2);
    finish_txn("rom_rd", 0, '0, 10, 0, '0);

    issue(32'h0000_0008, 1'b1, 4'b1111, 32'hFFFF_FFFF);
    check("rom_wr_rden", {31'b0, rom_rden}, 32'd0);
    check("rom_wr_ram_we", {31'b0, ram_we}, 32'd0);
    expect_resp("rom_wr", 1'b1, exp_rdata, 1);
    finish_txn("rom_wr", 0, '0, 10, 0, '0);

    // Unmapped read keeps previous rdata
    issue(32'h3000_0000, 1'b0, 4'b1111, '0);
    check("unmap_rden", {31'b0, rom_rden}, 32'd0);
    check("unmap_ram_we", {31'b0, ram_we}, 32'd0);
    expect_resp("unmap", 1'b1, exp_rdata, 1);
    finish_txn("unmap", 0, '0, 10, 0, '0);

    issue(32'h0000_0040, 1'b0, 4'b1111, '0);
    expect_resp("rom_rd2", 1'b0, 32'hB000_0010, 2);
    finish_txn("rom_rd2", 0, '0, 10, 0, '0);

    // Partial halfword write merges into zeroed RAM word
    issue(32'h1000_0020, 1'b1, 4'b0011, 32'hCAFE_F00D);
    expect_resp("ram_wr_h", 1'b0, exp_rdata, 1);
    finish_txn("ram_wr_h", 0, '0, 10, 0, '0);
    issue(32'h1000_0020, 1'b0, 4'b1111, '0);
    expect_resp("ram_rd_h", 1'b0, 32'h0000_F00D, 2);
    finish_txn("ram_rd_h", 0, '0, 10, 0, '0);

    // Peripheral read, ack three cycles in
    issue(32'h2000_0004, 1'b0, 4'b1111, '0);
    expect_resp("per_rd", 1'b0, 32'h0000_0055, 4);
    finish_txn("per_rd", 3, 32'h0000_0055, 20, 1, 16'h0004);

    // Peripheral write leaves rdata alone
    issue(32'h2000_0100, 1'b1, 4'b1100, 32'h7777_8888);
    expect_resp("per_wr", 1'b0, exp_rdata, 2);
    finish_txn("per_wr", 1, 32'hFFFF_FFFF, 20, 1, 16'h0100);

    // No ack: timeout after 255 wait cycles
    issue(32'h2000_0004, 1'b0, 4'b1111, '0);
    expect_resp("per_to", 1'b1, exp_rdata, 256);
    finish_txn("per_to", 0, '0, 300, 1, 16'h0004);

    // Ack in the timeout cycle wins
    issue(32'h2000_0008, 1'b0, 4'b1111, '0);
    expect_resp("per_late", 1'b0, 32'h0000_A5A5, 256);
    finish_txn("per_late", 255, 32'h0000_A5A5, 300, 1, 16'h0008);

    // Non-contiguous byte enables
    issue(32'h1000_0030, 1'b1, 4'b0101, 32'h1122_3344);
`ifdef MEM_ALIGN_CHECK_EN
    check("be0101_we", {31'b0, ram_we}, 32'd0);
    expect_resp("be0101", 1'b1, exp_rdata, 1);
    finish_txn("be0101", 0, '0, 10, 0, '0);
    issue(32'h1000_0030, 1'b0, 4'b1111, '0);
    expect_resp("be0101_rd", 1'b0, 32'h0000_0000, 2);
`else
    check("be0101_we", {31'b0, ram_we}, 32'd1);
    expect_resp("be0101", 1'b0, exp_rdata, 1);
    finish_txn("be0101", 0, '0, 10, 0, '0);
    issue(32'h1000_0030, 1'b0, 4'b1111, '0);
    expect_resp("be0101_rd", 1'b0, 32'h0022_0044, 2);
`endif
    finish_txn("be0101_rd", 0, '0, 10, 0, '0);

    // Reset during MEM_WAIT aborts without a response
    issue(32'h1000_0010, 1'b0, 4'b1111, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_req = 1'b0;
    #1;
    check("midrst_valid", {31'b0, mem_valid}, 32'd0);
    check("midrst_rdata", mem_rdata, 32'd0);
    check("midrst_err", {31'b0, mem_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_valid2", {31'b0, mem_valid}, 32'd0);
    rst = 1'b0;
    exp_rdata = '0;
    @(posedge clk);
    #1;
    issue(32'h1000_0010, 1'b0, 4'b1111, '0);
    expect_resp("post_rst_rd", 1'b0, 32'hDEAD_BEEF, 2);
    finish_txn("post_rst_rd", 0, '0, 10, 0, '0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
